// File: rtl/pong_draw_ctrl.sv
// Per-frame draw sequencer: streams the erase sweep in background colour,
// pulses the game update, then rasterises the ball and the paddle.
module pong_draw_ctrl #(
  parameter int unsigned ERASE_CYCLES  = 1276,
  parameter int unsigned BALL_SIZE     = 4,
  parameter int unsigned PADDLE_X      = 10,
  parameter int unsigned PADDLE_W      = 2,
  parameter int unsigned PADDLE_H      = 16,
  parameter logic [2:0]  BG_COLOUR     = 3'b000,
  parameter logic [2:0]  BALL_COLOUR   = 3'b111,
  parameter logic [2:0]  PADDLE_COLOUR = 3'b111
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic [7:0] eraseX,
  input  logic [6:0] eraseY,
  input  logic [7:0] ballX,
  input  logic [6:0] ballY,
  input  logic [6:0] paddleY,
  output logic       erase_resetn,
  output logic       update_en,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned EraseW = (ERASE_CYCLES > 1) ? $clog2(ERASE_CYCLES) : 1;
  localparam int unsigned SubMaxA = (BALL_SIZE > PADDLE_W) ? BALL_SIZE : PADDLE_W;
  localparam int unsigned SubMax = (SubMaxA > PADDLE_H) ? SubMaxA : PADDLE_H;
  localparam int unsigned SubW = (SubMax > 1) ? $clog2(SubMax) : 1;

  localparam logic [EraseW-1:0] EraseLast = EraseW'(ERASE_CYCLES - 1);
  localparam logic [SubW-1:0]   BallLast  = SubW'(BALL_SIZE - 1);
  localparam logic [SubW-1:0]   PadWLast  = SubW'(PADDLE_W - 1);
  localparam logic [SubW-1:0]   PadHLast  = SubW'(PADDLE_H - 1);

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    UPDATE,
    LATCH,
    DRAW_BALL,
    DRAW_PADDLE
  } state_t;

  state_t            state;
  logic [EraseW-1:0] eraseCnt;
  logic [SubW-1:0]   cx;
  logic [SubW-1:0]   cy;
  logic [7:0]        ballXL;
  logic [6:0]        ballYL;
  logic [6:0]        paddleYL;

  // Control outputs are registered with the state they belong to, so each
  // one changes on the same edge as the state it decodes.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= IDLE;
      eraseCnt     <= '0;
      cx           <= '0;
      cy           <= '0;
      ballXL       <= '0;
      ballYL       <= '0;
      paddleYL     <= '0;
      plot         <= 1'b0;
      colour       <= '0;
      erase_resetn <= 1'b0;
      update_en    <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (frame_tick && busy) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (frame_tick) begin
            state        <= ERASE;
            eraseCnt     <= '0;
            erase_resetn <= 1'b1;
            plot         <= 1'b1;
            colour       <= BG_COLOUR;
            busy         <= 1'b1;
          end
        end

        ERASE: begin
          if (eraseCnt == EraseLast) begin
            state        <= UPDATE;
            erase_resetn <= 1'b0;
            plot         <= 1'b0;
            colour       <= '0;
            update_en    <= 1'b1;
          end else begin
            eraseCnt <= eraseCnt + EraseW'(1);
          end
        end

        UPDATE: begin
          state     <= LATCH;
          update_en <= 1'b0;
        end

        // Positions are sampled once here so later input changes cannot tear the sprites.
        LATCH: begin
          state    <= DRAW_BALL;
          ballXL   <= ballX;
          ballYL   <= ballY;
          paddleYL <= paddleY;
          cx       <= '0;
          cy       <= '0;
          plot     <= 1'b1;
          colour   <= BALL_COLOUR;
        end

        DRAW_BALL: begin
          if (cx == BallLast) begin
            cx <= '0;
            if (cy == BallLast) begin
              cy     <= '0;
              state  <= DRAW_PADDLE;
              colour <= PADDLE_COLOUR;
            end else begin
              cy <= cy + SubW'(1);
            end
          end else begin
            cx <= cx + SubW'(1);
          end
        end

        DRAW_PADDLE: begin
          if (cx == PadWLast) begin
            cx <= '0;
            if (cy == PadHLast) begin
              cy     <= '0;
              state  <= IDLE;
              plot   <= 1'b0;
              colour <= '0;
              busy   <= 1'b0;
            end else begin
              cy <= cy + SubW'(1);
            end
          end else begin
            cx <= cx + SubW'(1);
          end
        end

        default: begin
          state        <= IDLE;
          plot         <= 1'b0;
          colour       <= '0;
          erase_resetn <= 1'b0;
          update_en    <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

  // Plot coordinates: erase sweep passes straight through; sprites wrap freely.
  always_comb begin
    x = '0;
    y = '0;
    case (state)
      ERASE: begin
        x = eraseX;
        y = eraseY;
      end
      DRAW_BALL: begin
        x = ballXL + 8'(cx);
        y = ballYL + 7'(cy);
      end
      DRAW_PADDLE: begin
        x = 8'(PADDLE_X) + 8'(cx);
        y = paddleYL + 7'(cy);
      end
      default: begin
        x = '0;
        y = '0;
      end
    endcase
  end

endmodule
